// File: rtl/sc_mult_scheduler.sv
// Sequencing controller for a unipolar stochastic multiplier: accepts a binary operand
// pair, streams 2^(2W) deterministic bit pairs through sc_multiplier and returns the ones count.

module sc_multiplier (
    input  logic a_bit,
    input  logic b_bit,
    output logic p_bit
);
    // Unipolar stochastic product of two uncorrelated streams is a single AND.
    assign p_bit = a_bit & b_bit;
endmodule

module sc_mult_scheduler #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           abort,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res,
    output logic           busy,
    output logic           x_bit,
    output logic           y_bit,
    output logic           p_bit,
    output logic           stream_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2*W-1:0] CNT_LAST = '1;
    localparam logic [2*W-1:0] CNT_ONE  = {{(2*W-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [2*W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] res_q, res_d;
    logic [W-1:0]   xr_q, xr_d;
    logic [W-1:0]   yr_q, yr_d;
    logic           in_ready_q, in_ready_d;
    logic           res_valid_q, res_valid_d;
    logic           busy_q, busy_d;
    logic           stream_valid_q, stream_valid_d;

    logic x_cmp, y_cmp, p_raw;

    // Low counter digit sweeps fastest, high digit slowest: the two streams are
    // clock-divided versions of each other and therefore uncorrelated over L cycles.
    assign x_cmp = stream_valid_q & (cnt_q[W-1:0]   < xr_q);
    assign y_cmp = stream_valid_q & (cnt_q[2*W-1:W] < yr_q);

    sc_multiplier u_mult (
        .a_bit (x_cmp),
        .b_bit (y_cmp),
        .p_bit (p_raw)
    );

    assign in_ready     = in_ready_q;
    assign res_valid    = res_valid_q;
    assign res          = res_q;
    assign busy         = busy_q;
    assign stream_valid = stream_valid_q;
    assign x_bit        = x_cmp;
    assign y_bit        = y_cmp;
    assign p_bit        = p_raw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        xr_d    = xr_q;
        yr_d    = yr_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    xr_d    = x;
                    yr_d    = y;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_q + {{(2*W-1){1'b0}}, p_raw};
                    cnt_d = cnt_q + CNT_ONE;
                    // Terminal cycle: the last stream bit is folded into the result.
                    if (cnt_q == CNT_LAST) begin
                        res_d   = acc_d;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (abort || res_ready) begin
                    res_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d     = (state_d == S_IDLE);
        res_valid_d    = (state_d == S_DONE);
        busy_d         = (state_d != S_IDLE);
        stream_valid_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            acc_q          <= '0;
            res_q          <= '0;
            xr_q           <= '0;
            yr_q           <= '0;
            in_ready_q     <= 1'b1;
            res_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            stream_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            res_q          <= res_d;
            xr_q           <= xr_d;
            yr_q           <= yr_d;
            in_ready_q     <= in_ready_d;
            res_valid_q    <= res_valid_d;
            busy_q         <= busy_d;
            stream_valid_q <= stream_valid_d;
        end
    end

endmodule
